// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID queue.
// slave is the queue side; master is the fetch/decode environment side.
interface if_id_queue_if #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int DEPTH_LOG2 = 2
);
  logic                  if_valid;
  logic [ADDR_W-1:0]     if_pc;
  logic [INST_W-1:0]     if_inst;
  logic                  if_pred;
  logic                  if_ready;
  logic                  id_valid;
  logic [ADDR_W-1:0]     id_pc;
  logic [INST_W-1:0]     id_inst;
  logic                  id_pred;
  logic                  id_ready;
  logic [DEPTH_LOG2:0]   count;

  modport slave (
    input  if_valid, if_pc, if_inst, if_pred, id_ready,
    output if_ready, id_valid, id_pc, id_inst, id_pred, count
  );

  modport master (
    output if_valid, if_pc, if_inst, if_pred, id_ready,
    input  if_ready, id_valid, id_pc, id_inst, id_pred, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular FIFO of 2**DEPTH_LOG2 {pc, inst, pred}
// entries between fetch and decode, with global enable (rdy) and flush.
// Optional macro IF_ID_QUEUE_BYPASS_EN: when the queue is empty, a fetch
// entry is forwarded combinationally to decode (zero-cycle latency).
module if_id_queue #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          flush,
  if_id_queue_if.slave  q
);
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = ADDR_W + INST_W + 1;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // Entry layout: {pred, inst, pc}
  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0] head_reg;
  logic [DEPTH_LOG2-1:0] tail_reg;
  logic [DEPTH_LOG2:0]   count_reg;

  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  bypass_active;
  logic                  bypass_take;
  logic [ENTRY_W-1:0]    head_entry;

  // Handshake decode: push/pop qualifiers and the optional bypass path
  always_comb begin
    empty      = (count_reg == '0);
    full       = (count_reg == FULL_COUNT);
    head_entry = mem[head_reg];
`ifdef IF_ID_QUEUE_BYPASS_EN
    bypass_active = empty & q.if_valid & ~flush;
`else
    bypass_active = 1'b0;
`endif
    // A bypassed entry that decode takes this cycle never enters storage
    bypass_take = bypass_active & rdy & q.id_ready;
    push = rdy & q.if_valid & ~full & ~flush & ~bypass_take;
    // Only stored entries are popped; an empty queue cannot pop
    pop  = rdy & ~empty & q.id_ready & ~flush;
  end

  // Output drive: head entry when non-empty, zero bubble otherwise
  always_comb begin
    q.if_ready = ~full;
    q.count    = count_reg;
    q.id_valid = ~empty;
    q.id_pc    = '0;
    q.id_inst  = '0;
    q.id_pred  = 1'b0;
    if (!empty) begin
      q.id_pc   = head_entry[ADDR_W-1:0];
      q.id_inst = head_entry[ADDR_W +: INST_W];
      q.id_pred = head_entry[ENTRY_W-1];
    end
    if (bypass_active) begin
      q.id_valid = 1'b1;
      q.id_pc    = q.if_pc;
      q.id_inst  = q.if_inst;
      q.id_pred  = q.if_pred;
    end
  end

  // Entry storage: cleared on reset, written at tail on push
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[tail_reg] <= {q.if_pred, q.if_inst, q.if_pc};
    end
  end

  // Pointer and occupancy update; flush empties, rdy=0 freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (rdy) begin
      if (flush) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push) tail_reg <= tail_reg + DEPTH_LOG2'(1);
        if (pop)  head_reg <= head_reg + DEPTH_LOG2'(1);
        if (push && !pop)
          count_reg <= count_reg + (DEPTH_LOG2 + 1)'(1);
        else if (pop && !push)
          count_reg <= count_reg - (DEPTH_LOG2 + 1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (default DEPTH=4).
// Honors IF_ID_QUEUE_BYPASS_EN to pick the expected bypass behaviour.
module tb_if_id_queue;
  logic clk = 1'b0;
  logic rst, rdy, flush;
  int   checks = 0;
  int   errors = 0;

  if_id_queue_if #(.ADDR_W(32), .INST_W(32), .DEPTH_LOG2(2)) bus ();

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH_LOG2(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .q     (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic ir);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = 32'h1000 + pc;
    bus.if_pred  = pc[2];
    bus.id_ready = ir;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h99, 1'b1);
    step();
    step();
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %b want 0", bus.id_valid); end
    checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h want 0", bus.id_pc); end
    checks++; if (bus.id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst got %h want 0", bus.id_inst); end
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready got %b want 1", bus.if_ready); end
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    $display("reset done count=%0d", bus.count);
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(4 * k), 1'b0);
      step();
      $display("push pc=%h count=%0d", 4 * k, bus.count);
    end
    drive(1'b0, 32'h0, 1'b0);
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", bus.count); end
    checks++; if (bus.if_ready !== 1'b0) begin errors++; $display("FAIL fill_if_ready got %b want 0", bus.if_ready); end
    checks++; if (bus.id_inst !== 32'h1000) begin errors++; $display("FAIL fill_id_inst got %h want 1000", bus.id_inst); end
    // Fifth entry must be refused while full
    drive(1'b1, 32'h10, 1'b0);
    step();
    $display("push pc=10 (full) count=%0d", bus.count);
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_reject_count got %0d want 4", bus.count); end
    checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL full_reject_id_pc got %h want 0", bus.id_pc); end
    // Full with decode ready: pop only, space reopens next cycle
    drive(1'b1, 32'h10, 1'b1);
    step();
    $display("pop at full count=%0d", bus.count);
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d want 3", bus.count); end
    checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL full_pop_if_ready got %b want 1", bus.if_ready); end
    checks++; if (bus.id_pc !== 32'h4) begin errors++; $display("FAIL full_pop_id_pc got %h want 4", bus.id_pc); end
    drive(1'b0, 32'h0, 1'b1);
    step();
    checks++; if (bus.id_pc !== 32'h8 || bus.count !== 3'd2) begin errors++; $display("FAIL drain_one got pc=%h count=%0d want pc=8 count=2", bus.id_pc, bus.count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    // Queue holds 8,C; ten push+pop cycles stream 0x100.. through it
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 1'b1);
      exp_pc = (k < 2) ? 32'h8 + 32'(4 * k) : 32'h100 + 32'(4 * (k - 2));
      $display("xfer push=%h pop=%h count=%0d", bus.if_pc, bus.id_pc, bus.count);
      checks++; if (bus.id_pc !== exp_pc) begin errors++; $display("FAIL b2b_order[%0d] got %h want %h", k, bus.id_pc, exp_pc); end
      checks++; if (bus.id_inst !== 32'h1000 + exp_pc) begin errors++; $display("FAIL b2b_inst[%0d] got %h want %h", k, bus.id_inst, 32'h1000 + exp_pc); end
      checks++; if (bus.id_pred !== exp_pc[2]) begin errors++; $display("FAIL b2b_pred[%0d] got %b want %b", k, bus.id_pred, exp_pc[2]); end
      step();
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d] got %0d want 2", k, bus.count); end
    end
    drive(1'b0, 32'h0, 1'b0);
    checks++; if (bus.id_pc !== 32'h120) begin errors++; $display("FAIL b2b_tail_head got %h want 120", bus.id_pc); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h200, 1'b0);
    step();
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL preflush_count got %0d want 3", bus.count); end
    flush = 1'b1;
    drive(1'b1, 32'h300, 1'b1);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    $display("flush count=%0d id_valid=%b", bus.count, bus.id_valid);
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", bus.count); end
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_id_valid got %b want 0", bus.id_valid); end
    checks++; if (bus.id_inst !== 32'h0) begin errors++; $display("FAIL flush_id_inst got %h want 0", bus.id_inst); end
    step();
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL flush_lost_entry got count %0d want 0", bus.count); end
  endtask

  task automatic test_freeze();
    drive(1'b1, 32'h400, 1'b0);
    step();
    drive(1'b1, 32'h404, 1'b0);
    step();
    rdy   = 1'b0;
    flush = 1'b1;
    drive(1'b1, 32'h500, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      $display("frozen count=%0d id_pc=%h", bus.count, bus.id_pc);
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL freeze_count[%0d] got %0d want 2", k, bus.count); end
      checks++; if (bus.id_pc !== 32'h400) begin errors++; $display("FAIL freeze_id_pc[%0d] got %h want 400", k, bus.id_pc); end
    end
    rdy   = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    step();
    checks++; if (bus.id_pc !== 32'h404 || bus.count !== 3'd1) begin errors++; $display("FAIL resume got pc=%h count=%0d want pc=404 count=1", bus.id_pc, bus.count); end
    step();
    checks++; if (bus.count !== 3'd0 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL resume_empty got count=%0d valid=%b want 0/0", bus.count, bus.id_valid); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 32'h40, 1'b1);
`ifdef IF_ID_QUEUE_BYPASS_EN
    $display("bypass id_valid=%b id_pc=%h", bus.id_valid, bus.id_pc);
    checks++; if (bus.id_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got %b want 1", bus.id_valid); end
    checks++; if (bus.id_pc !== 32'h40) begin errors++; $display("FAIL bypass_pc got %h want 40", bus.id_pc); end
    step();
    drive(1'b0, 32'h0, 1'b1);
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL bypass_count got %0d want 0", bus.count); end
`else
    $display("no-bypass id_valid=%b", bus.id_valid);
    checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL nobypass_valid got %b want 0", bus.id_valid); end
    step();
    drive(1'b0, 32'h0, 1'b1);
    checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h40) begin errors++; $display("FAIL nobypass_next got valid=%b pc=%h want 1/40", bus.id_valid, bus.id_pc); end
    step();
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL nobypass_drain got %0d want 0", bus.count); end
`endif
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h600, 1'b0);
    step();
    drive(1'b1, 32'h604, 1'b0);
    step();
    rst   = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'h608, 1'b1);
    step();
    rst   = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    $display("mid reset count=%0d", bus.count);
    checks++; if (bus.count !== 3'd0 || bus.id_pc !== 32'h0) begin errors++; $display("FAIL midreset got count=%0d pc=%h want 0/0", bus.count, bus.id_pc); end
  endtask

  initial begin
    rst   = 1'b1;
    rdy   = 1'b1;
    flush = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_pc    = '0;
    bus.if_inst  = '0;
    bus.if_pred  = 1'b0;
    bus.id_ready = 1'b0;
    test_reset();
    test_fill();
    test_back_to_back();
    test_flush();
    test_freeze();
    test_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- Circular FIFO of DEPTH entries between fetch and decode. Each entry holds pc, inst and the predicted-taken bit.
- Decouples fetch from decode stalls with valid/ready handshakes on both sides.
- A single-cycle flush (branch mispredict or redirect) empties the queue. While empty, the ID side presents a zero-word bubble.

Parameters:
- ADDR_W, 32, width of pc fields.
- INST_W, 32, width of instruction fields.
- DEPTH_LOG2, 2, log2 of entry count. DEPTH = 2**DEPTH_LOG2. Legal range 1..5.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global enable. 0 freezes all state; reset still applies.
- flush  in  1  mispredict/redirect; discards all entries.
- if_valid  in  1  fetch presents an entry.
- if_pc  in  ADDR_W  fetched pc.
- if_inst  in  INST_W  fetched instruction.
- if_pred  in  1  predictor said taken.
- if_ready  out  1  queue can accept an entry this cycle.
- id_valid  out  1  head entry valid.
- id_pc  out  ADDR_W  head pc.
- id_inst  out  INST_W  head instruction.
- id_pred  out  1  head prediction bit.
- id_ready  in  1  decode accepts the head (low = decode stalled).
- count  out  DEPTH_LOG2+1  number of stored entries.

Behaviour:
- Storage is DEPTH entries of {pc, inst, pred}.
  - head and tail pointers are DEPTH_LOG2 bits; they wrap DEPTH-1 -> 0 by natural overflow.
  - count is DEPTH_LOG2+1 bits, range 0..DEPTH.
- Reset (rst=1 at edge, regardless of rdy): head=tail=0, count=0, all storage cleared to 0. Resulting outputs: id_valid=0, id_pc=0, id_inst=0, id_pred=0, count=0, if_ready=1.
- Output and ready logic:
  - if_ready = (count != DEPTH). Combinational from count only; no pass-through when full.
  - push = rdy & if_valid & if_ready & ~flush.
  - pop = rdy & id_valid & id_ready & ~flush.
  - id_valid = (count != 0).
  - id_pc/id_inst/id_pred = storage[head] when id_valid, else all zero (bubble). No X ever driven.
- Update rules:
  - push: storage[tail] <= if_*, tail+1.
  - pop: head+1.
  - count: +1 push only, -1 pop only, unchanged for both or neither.
- Latency: an entry pushed at edge N is visible on id_* after edge N (one cycle, registered storage).
- Flush (rdy=1): head=tail=0, count=0. A same-cycle push and pop are both suppressed. id_valid=0 the following cycle. Storage contents need not be cleared.
- rdy=0: no state changes and flush is ignored; upstream holds flush until rdy=1. Outputs keep reflecting current state.
- Boundary cases:
  - Full with id_ready=1: pop only; if_ready=1 next cycle.
  - Empty: push only; pop impossible.
  - Reset asserted mid-operation overrides flush, push and pop.
- Ordering: strict FIFO; entries never reordered or duplicated.

Optional Feature:
- Macro IF_ID_QUEUE_BYPASS_EN.
- Defined: when count==0 and if_valid=1 and flush=0:
  - id_valid=1 and id_* = if_* combinationally.
  - If id_ready=1 and rdy=1, the entry is consumed with no push and count stays 0.
  - If id_ready=0, a normal push occurs.
  - Zero-cycle latency when empty.
- Undefined: no bypass; minimum latency one cycle as above.

Test Plan:
- Reset: rst=1 for 2 cycles with if_valid=1 -> count=0, id_valid=0, id_pc=0, id_inst=0, if_ready=1.
- Fill with id_ready=0 (default DEPTH=4): push pc 0x00,0x04,0x08,0x0C -> count=4, if_ready=0; a fifth entry 0x10 is not accepted; id_pc=0x00.
- Simultaneous push/pop at count=2, plus wrap:
  - id_ready=1, if_valid=1 -> count stays 2, head advances.
  - Run 10 entries through; id_pc sequence equals push sequence exactly, with wrap past index 3.
- Flush: count=3, assert flush with if_valid=1, id_ready=1 -> next cycle count=0, id_valid=0, id_inst=0; the same-cycle fetch entry is lost.
- rdy freeze: count=2, rdy=0 with if_valid=1, id_ready=1, flush=1 for 3 cycles -> count=2, same id_pc. Then rdy=1 resumes normally.
- Bypass (IF_ID_QUEUE_BYPASS_EN defined), empty queue, if_valid=1, if_pc=0x40, id_ready=1 -> same cycle id_valid=1, id_pc=0x40; count remains 0. Without the macro: id_valid=0 that cycle and id_pc=0x40 the next cycle.
